// File: rtl/alert_ping_sched.sv
// Round-robin ping scheduler for alert channels: waits a period, pings one enabled
// channel, and waits for its ack or a timeout before moving on.
module alert_ping_sched #(
  parameter int NumAlerts = 4,
  parameter int CntW      = 16,
  localparam int SelW     = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NumAlerts-1:0] alert_en_i,
  input  logic [CntW-1:0]      period_i,
  input  logic [CntW-1:0]      timeout_i,
  output logic [NumAlerts-1:0] ping_req_o,
  input  logic [NumAlerts-1:0] ping_ok_i,
  output logic                 ping_done_o,
  output logic [NumAlerts-1:0] ping_fail_o,
  output logic                 busy_o,
  output logic [SelW-1:0]      sel_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StPing = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SelW-1:0]       ptr_q, ptr_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic                  done_q, done_d;
  logic [NumAlerts-1:0]  fail_q, fail_d;

  logic                  run_c;
  logic                  found_c;
  logic [SelW:0]         sum_c;
  logic [SelW-1:0]       pick_c;
  logic [SelW-1:0]       sel_next_c;

  assign run_c      = en_i && (|alert_en_i);
  assign sel_next_c = (sel_q == SelW'(NumAlerts - 1)) ? '0 : sel_q + SelW'(1);

  // First enabled channel at or after ptr, wrapping around the bank.
  always_comb begin
    found_c = 1'b0;
    sum_c   = '0;
    pick_c  = ptr_q;
    for (int i = 0; i < NumAlerts; i++) begin
      sum_c = {1'b0, ptr_q} + (SelW+1)'(i);
      if (sum_c >= (SelW+1)'(NumAlerts)) sum_c = sum_c - (SelW+1)'(NumAlerts);
      if (!found_c && alert_en_i[sum_c[SelW-1:0]]) begin
        found_c = 1'b1;
        pick_c  = sum_c[SelW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    fail_d  = '0;
    case (state_q)
      StIdle: begin
        if (run_c) begin
          cnt_d   = period_i;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!run_c) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          sel_d   = pick_c;
          cnt_d   = timeout_i;
          state_d = StPing;
        end
      end
      StPing: begin
        if (!run_c) begin
          state_d = StIdle;
        end else if (!alert_en_i[sel_q]) begin
          ptr_d   = sel_next_c;
          cnt_d   = period_i;
          state_d = StWait;
        end else if (ping_ok_i[sel_q]) begin
          // Ack takes priority over a timeout landing in the same cycle.
          done_d  = 1'b1;
          ptr_d   = sel_next_c;
          cnt_d   = period_i;
          state_d = StWait;
        end else if (cnt_q == '0) begin
          fail_d[sel_q] = 1'b1;
          ptr_d   = sel_next_c;
          cnt_d   = period_i;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    ping_req_o = '0;
    if (state_q == StPing) ping_req_o[sel_q] = 1'b1;
  end

  assign ping_done_o = done_q;
  assign ping_fail_o = fail_q;
  assign busy_o      = (state_q == StWait) || (state_q == StPing);
  assign sel_o       = sel_q;

endmodule
